// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/response, redirect input and decode-side handshake.
interface instr_fetch_unit_if #(
    parameter int unsigned PC_WIDTH = 32
);
    logic                imem_req_valid;
    logic                imem_req_ready;
    logic [PC_WIDTH-1:0] imem_req_addr;
    logic                imem_rsp_valid;
    logic [31:0]         imem_rsp_data;
    logic                redirect_valid;
    logic [PC_WIDTH-1:0] redirect_pc;
    logic                inst_valid;
    logic                inst_ready;
    logic [31:0]         inst_data;
    logic [PC_WIDTH-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, inst_ready
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: credit-limited word fetches, in-order buffering, and redirect flush
// that discards in-flight responses.
module instr_fetch_unit #(
    parameter int unsigned         PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = '0,
    parameter int unsigned         BUF_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    localparam int unsigned      PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned      CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_MAX = PTR_W'(BUF_DEPTH - 1);

    logic [PC_WIDTH-1:0] r_fetch_pc;
    logic [CNT_W-1:0]    r_outstanding;
    logic [CNT_W-1:0]    r_drop_cnt;
    logic [CNT_W-1:0]    r_count;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_tag_rd;
    logic [PTR_W-1:0]    r_tag_wr;
    logic [31:0]         r_buf_data [BUF_DEPTH];
    logic [PC_WIDTH-1:0] r_buf_pc   [BUF_DEPTH];
    logic [PC_WIDTH-1:0] r_tag_pc   [BUF_DEPTH];
    logic                r_active;

    logic [CNT_W:0]      w_used;
    logic                w_req_fire;
    logic                w_rsp_fire;
    logic                w_push;
    logic                w_pop;
    logic [CNT_W-1:0]    w_outstanding_nxt;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_MAX) ? '0 : p + PTR_W'(1);
    endfunction

    // r_active holds requests off until the first edge after reset release.
    assign w_used             = {1'b0, r_outstanding} + {1'b0, r_count};
    assign bus.imem_req_valid = r_active && (w_used < (CNT_W + 1)'(BUF_DEPTH)) && !bus.redirect_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = (r_count != '0);
    assign bus.inst_data      = r_buf_data[r_rd_ptr];
    assign bus.inst_pc        = r_buf_pc[r_rd_ptr];

    assign w_req_fire = bus.imem_req_valid && bus.imem_req_ready;
    assign w_rsp_fire = bus.imem_rsp_valid && (r_outstanding != '0);
    assign w_push     = w_rsp_fire && (r_drop_cnt == '0) && !bus.redirect_valid;
    assign w_pop      = bus.inst_valid && bus.inst_ready;

    always_comb begin
        w_outstanding_nxt = r_outstanding;
        if (w_req_fire && !w_rsp_fire) begin
            w_outstanding_nxt = r_outstanding + CNT_W'(1);
        end else if (!w_req_fire && w_rsp_fire) begin
            w_outstanding_nxt = r_outstanding - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active      <= 1'b0;
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_tag_rd      <= '0;
            r_tag_wr      <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                r_buf_data[i] <= '0;
                r_buf_pc[i]   <= '0;
                r_tag_pc[i]   <= '0;
            end
        end else begin
            r_active      <= 1'b1;
            r_outstanding <= w_outstanding_nxt;
            if (w_req_fire) begin
                r_fetch_pc         <= r_fetch_pc + PC_WIDTH'(4);
                r_tag_pc[r_tag_wr] <= r_fetch_pc;
                r_tag_wr           <= f_inc(r_tag_wr);
            end
            if (w_rsp_fire) begin
                r_tag_rd <= f_inc(r_tag_rd);
            end
            // Tags of dropped responses still pop normally, so the tag queue survives a redirect.
            if (bus.redirect_valid) begin
                r_fetch_pc <= {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};
                r_count    <= '0;
                r_rd_ptr   <= r_wr_ptr;
                r_drop_cnt <= w_outstanding_nxt;
            end else begin
                if (w_rsp_fire && (r_drop_cnt != '0)) begin
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
                end
                if (w_push) begin
                    r_buf_data[r_wr_ptr] <= bus.imem_rsp_data;
                    r_buf_pc[r_wr_ptr]   <= r_tag_pc[r_tag_rd];
                    r_wr_ptr             <= f_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= f_inc(r_rd_ptr);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    a_rsp_has_request: assert property (@(posedge clk) disable iff (!rst_n)
        bus.imem_rsp_valid |-> (r_outstanding != '0));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: queue-based reference model, randomized memory/decode behaviour, directed scenarios.
module tb_instr_fetch_unit;
    localparam int unsigned BD       = 2;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.PC_WIDTH(32)) bus ();

    instr_fetch_unit #(
        .PC_WIDTH (32),
        .RESET_PC (RESET_PC),
        .BUF_DEPTH(BD)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.master)
    );

    a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) dut.r_count <= BD);

    typedef struct { logic [31:0] pc; bit drop; } fl_t;
    typedef struct { logic [31:0] data; logic [31:0] pc; } ent_t;
    typedef struct { logic [31:0] addr; int c; } mr_t;

    fl_t         m_fl[$];
    ent_t        m_buf[$];
    logic [31:0] m_pc;
    bit          m_live;
    mr_t         mem_q[$];

    logic [31:0] acc_addr[$];
    int          acc_cyc[$];
    logic [31:0] shown_pc[$];
    int          shown_cyc[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int p_ready, p_rsp, p_iready, p_redir;
    bit force_redir = 0;
    logic [31:0] force_pc = '0;
    bit e_mode = 0;
    bit e_done = 0;
    logic last_rv, last_iv;
    logic [31:0] last_addr;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_0000;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
    endtask

    task automatic set_knobs(input int r, input int s, input int i, input int d);
        p_ready = r; p_rsp = s; p_iready = i; p_redir = d;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        m_fl.delete(); m_buf.delete(); mem_q.delete();
        m_pc = RESET_PC; m_live = 0;
        #1;
        chk("rst_inst_valid", bus.inst_valid, 0);
        chk("rst_req_valid", bus.imem_req_valid, 0);
        chk("rst_inst_data", bus.inst_data, 0);
        chk("rst_inst_pc", bus.inst_pc, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        m_live = 1;
        acc_addr.delete(); acc_cyc.delete(); shown_pc.delete(); shown_cyc.delete();
    endtask

    // One cycle: drive at negedge, compare against the model, advance the model at posedge.
    task automatic step();
        bit exp_rv, exp_iv, rsp, redir;
        logic [31:0] rpc;
        fl_t f;
        @(negedge clk);
        cyc++;
        rsp = (mem_q.size() > 0) && (mem_q[0].c < cyc) && ($urandom_range(99) < p_rsp);
        redir = force_redir || (p_redir > 0 && $urandom_range(999) < p_redir);
        rpc = force_redir ? force_pc : $urandom;
        if (e_mode && bus.inst_valid && rsp) begin
            redir = 1; rpc = 32'h2000; e_mode = 0; e_done = 1;
        end
        bus.imem_req_ready = ($urandom_range(99) < p_ready);
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(mem_q[0].addr) : $urandom;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        bus.inst_ready     = ($urandom_range(99) < p_iready);
        #1;
        exp_rv = m_live && (m_fl.size() + m_buf.size() < BD) && !redir;
        exp_iv = (m_buf.size() > 0);
        chk("req_valid", bus.imem_req_valid, exp_rv);
        if (exp_rv) chk("req_addr", bus.imem_req_addr, m_pc);
        chk("inst_valid", bus.inst_valid, exp_iv);
        if (exp_iv) begin
            chk("inst_data", bus.inst_data, m_buf[0].data);
            chk("inst_pc", bus.inst_pc, m_buf[0].pc);
        end
        last_rv = bus.imem_req_valid; last_iv = bus.inst_valid; last_addr = bus.imem_req_addr;
        if (bus.imem_req_valid && bus.imem_req_ready) begin
            mem_q.push_back('{bus.imem_req_addr, cyc});
            acc_addr.push_back(bus.imem_req_addr);
            acc_cyc.push_back(cyc);
        end
        if (bus.inst_valid) begin
            shown_pc.push_back(bus.inst_pc);
            shown_cyc.push_back(cyc);
        end
        if (rsp) void'(mem_q.pop_front());
        @(posedge clk);
        if (exp_iv && bus.inst_ready) void'(m_buf.pop_front());
        if (rsp && m_fl.size() > 0) begin
            f = m_fl.pop_front();
            if (!f.drop && !redir) m_buf.push_back('{bus.imem_rsp_data, f.pc});
        end
        if (exp_rv && bus.imem_req_ready) begin
            m_fl.push_back('{m_pc, 1'b0});
            m_pc = m_pc + 32'd4;
        end
        if (redir) begin
            m_buf.delete();
            foreach (m_fl[i]) m_fl[i].drop = 1;
            m_pc = {rpc[31:2], 2'b00};
        end
    endtask

    initial begin
        int n_acc, n_shown, stale, pop_cyc, n;
        idle_inputs();

        // Zero-wait memory, decode always ready.
        set_knobs(100, 100, 100, 0);
        do_reset();
        repeat (10) step();
        chk("A_addr0", acc_addr[0], 32'h0);
        chk("A_addr1", acc_addr[1], 32'h4);
        chk("A_addr2", acc_addr[2], 32'h8);
        chk("A_first_valid_lat", shown_cyc[0] - acc_cyc[0], 2);
        chk("A_first_pc", shown_pc[0], 32'h0);

        // Decode stalled: credit exhausts after BD requests, one pop frees one.
        set_knobs(100, 100, 0, 0);
        do_reset();
        repeat (6) step();
        chk("B_acc_count", acc_addr.size(), 2);
        chk("B_req_blocked", last_rv, 0);
        p_iready = 100;
        step();
        pop_cyc = cyc;
        chk("B_pop_valid", last_iv, 1);
        p_iready = 0;
        repeat (3) step();
        chk("B_third_addr", acc_addr[2], 32'h8);
        chk("B_third_lat", acc_cyc[2] - pop_cyc, 1);

        // Memory not ready: request held stable.
        set_knobs(0, 100, 100, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step();
            chk("C_valid_held", last_rv, 1);
            chk("C_addr_held", last_addr, 32'h0);
        end
        chk("C_no_accept", acc_addr.size(), 0);
        p_ready = 100;
        step();
        step();
        chk("C_addr_after", last_addr, 32'h4);

        // Redirect with 0x8 and 0xC in flight.
        set_knobs(100, 0, 100, 0);
        do_reset();
        repeat (4) step();
        set_knobs(0, 100, 100, 0);
        repeat (4) step();
        set_knobs(100, 0, 100, 0);
        repeat (4) step();
        chk("D_inflight_8", acc_addr[2], 32'h8);
        chk("D_inflight_C", acc_addr[3], 32'hC);
        n_acc = acc_addr.size();
        n_shown = shown_pc.size();
        force_redir = 1; force_pc = 32'h103;
        step();
        force_redir = 0;
        set_knobs(100, 100, 100, 0);
        repeat (10) step();
        chk("D_next_addr", acc_addr[n_acc], 32'h100);
        chk("D_first_pc", shown_pc[n_shown], 32'h100);
        stale = 0;
        for (int i = n_shown; i < shown_pc.size(); i++)
            if (shown_pc[i] == 32'h8 || shown_pc[i] == 32'hC) stale++;
        chk("D_no_stale", stale, 0);

        // Redirect coinciding with a response and an inst handshake.
        set_knobs(100, 100, 100, 0);
        do_reset();
        repeat (6) step();
        e_mode = 1;
        for (int i = 0; i < 20 && !e_done; i++) step();
        e_mode = 0;
        chk("E_trigger", e_done, 1);
        n_shown = shown_pc.size();
        step();
        chk("E_valid_after", last_iv, 0);
        repeat (8) step();
        chk("E_first_pc", shown_pc[n_shown], 32'h2000);

        // Asynchronous reset with a full buffer.
        set_knobs(100, 100, 0, 0);
        do_reset();
        repeat (6) step();
        chk("F_full", last_iv, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("F_async_inst_valid", bus.inst_valid, 0);
        chk("F_async_req_valid", bus.imem_req_valid, 0);
        do_reset();
        set_knobs(100, 100, 100, 0);
        repeat (4) step();
        chk("F_restart_addr", acc_addr[0], RESET_PC);

        // Randomized traffic with random redirects.
        do_reset();
        for (int blk = 0; blk < 10; blk++) begin
            set_knobs($urandom_range(100, 30), $urandom_range(100, 30),
                      $urandom_range(100, 20), $urandom_range(60, 0));
            repeat (200) step();
        end
        n = acc_addr.size();
        if (n == 0) chk("G_progress", n, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
